kamus_dmem_responder: RTL

Memory-side responder for the core's data port: accepts load/store requests from the load-store unit over a valid/ready request channel and performs them on a word-organised data RAM with byte-lane writes. Returns read data or a write acknowledge on a valid/ready response channel, with a configurable number of wait states. Sits between the core's LSU and the data-memory array; it is the stand-in for the L1 data cache until one exists.

---
 rtl/kamus_pkg.sv | 36 +++
 rtl/kamus_sram_1p.sv | 29 ++
 rtl/kamus_dmem_responder.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/kamus_pkg.sv
// Shared types and helpers for the data-memory responder.
package kamus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    RESP
  } dmem_state_e;

  localparam logic [3:0] BE_B0 = 4'b0001;
  localparam logic [3:0] BE_B1 = 4'b0010;
  localparam logic [3:0] BE_B2 = 4'b0100;
  localparam logic [3:0] BE_B3 = 4'b1000;
  localparam logic [3:0] BE_H0 = 4'b0011;
  localparam logic [3:0] BE_H1 = 4'b1100;
  localparam logic [3:0] BE_W  = 4'b1111;

  // Only naturally aligned byte, halfword and word accesses are accepted.
  function automatic logic be_legal(input logic [3:0] be);
    case (be)
      BE_B0, BE_B1, BE_B2, BE_B3, BE_H0, BE_H1, BE_W: be_legal = 1'b1;
      default:                                         be_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/kamus_sram_1p.sv
// Single-port word RAM with byte-lane writes and a registered read port.
module kamus_sram_1p #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Contents are deliberately not reset; rdata only updates on a read.
  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (en && !we) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/kamus_dmem_responder.sv
// LSU-facing data-memory responder: one outstanding request, optional wait
// states, byte-lane stores and masked load data over valid/ready channels.
module kamus_dmem_responder
  import kamus_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_be_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = 3;

  dmem_state_e   state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          ready_q, ready_nxt;
  logic          valid_q, valid_nxt;
  logic          rsp_err_q, rsp_err_nxt;
  logic          ram_en, ram_we;
  logic          accept, req_err;
  logic          we_q, err_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    be_q;
  logic [31:0]   ram_rdata;
  logic          unused_addr_lsbs;

  assign accept  = (state == IDLE) && req_valid_i;
  assign req_err = (req_addr_i[31:2] >= 30'(DEPTH_WORDS)) || !be_legal(req_be_i);
  assign unused_addr_lsbs = &{1'b0, req_addr_i[1:0]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      cnt       <= '0;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      ready_q   <= ready_nxt;
      valid_q   <= valid_nxt;
      rsp_err_q <= rsp_err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    ready_nxt   = ready_q;
    valid_nxt   = valid_q;
    rsp_err_nxt = rsp_err_q;
    ram_en      = 1'b0;
    ram_we      = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid_i) begin
          ready_nxt = 1'b0;
          if (WAIT_STATES > 0) begin
            state_nxt = WAIT;
            cnt_nxt   = CW'(WAIT_STATES - 1);
          end else begin
            state_nxt = ACCESS;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) state_nxt = ACCESS;
        else           cnt_nxt   = cnt - CW'(1);
      end
      ACCESS: begin
        // Rejected requests never touch the RAM.
        ram_en      = !err_q;
        ram_we      = we_q;
        state_nxt   = RESP;
        valid_nxt   = 1'b1;
        rsp_err_nxt = err_q;
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_nxt   = IDLE;
          valid_nxt   = 1'b0;
          rsp_err_nxt = 1'b0;
          ready_nxt   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Holds the single outstanding request; only loaded on acceptance.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else if (accept) begin
      we_q    <= req_we_i;
      err_q   <= req_err;
      addr_q  <= req_addr_i[AW+1:2];
      wdata_q <= req_wdata_i;
      be_q    <= req_be_i;
    end
  end

  kamus_sram_1p #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .ADDR_W     (AW)
  ) u_sram (
    .clk  (clk_i),
    .en   (ram_en),
    .we   (ram_we),
    .be   (be_q),
    .addr (addr_q),
    .wdata(wdata_q),
    .rdata(ram_rdata)
  );

  // RAM read register is stable through RESP, so masking it keeps data held.
  assign rsp_rdata_o = (valid_q && !we_q && !err_q) ? (ram_rdata & be_mask(be_q)) : '0;
  assign req_ready_o = ready_q;
  assign rsp_valid_o = valid_q;
  assign rsp_err_o   = rsp_err_q;

endmodule
